// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Holds the loader FSM state encoding, memory address/data widths shared
// with the CPU controller and program memory, and the parameter defaults.
package program_loader_pkg;

   localparam int AW = 8;    // program memory address width
   localparam int DW = 16;   // instruction word width
   localparam int BW = 8;    // incoming byte width
   localparam int TW = 16;   // idle timeout counter width

   localparam logic [AW-1:0] BASE_ADDR_DEF = 8'h00;
   localparam logic [TW-1:0] TIMEOUT_DEF   = 16'd50000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_WRITE = 3'd4,
      ST_RUN   = 3'd5,
      ST_HALT  = 3'd6,
      ST_ERR   = 3'd7
   } ld_state_e;

endpackage

// File: rtl/program_loader_timeout.sv
// Idle-cycle watchdog for the loader.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr_i       clear the count (byte accepted, or not in a receiving state)
//   inc_i       count one idle cycle
//   expire_o    this idle cycle is the TIMEOUT-th one; the FSM leaves for ERR
module loader_timeout
   import program_loader_pkg::*;
#(
   parameter logic [TW-1:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   logic [TW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cnt_q <= '0;
      else if (clr_i)  cnt_q <= '0;
      else if (inc_i)  cnt_q <= cnt_q + 1'b1;
   end

   // Combinational so the FSM can let a byte arriving on the same cycle win.
   assign expire_o = inc_i && (cnt_q == TIMEOUT - 1'b1);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader.
// Receives a byte stream (valid/ready): header byte N, then N words sent
// high byte first. Each word is written to program memory through the
// controller's ext port at BASE_ADDR+k, then timer_en is raised until the
// CPU reports done.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   start             begin a load (honoured in IDLE, HALT, ERR)
//   rx_data/valid/ready  byte stream handshake
//   cpu_done          controller done level, sampled in RUN
//   ext_wen/addr/data program memory write port
//   timer_en          timing generator enable (RUN only)
//   busy, error       status; word_cnt = words written in current load
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [AW-1:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter logic [TW-1:0] TIMEOUT   = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [BW-1:0] rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic          cpu_done,
   output logic          ext_wen,
   output logic [AW-1:0] ext_addr,
   output logic [DW-1:0] ext_data,
   output logic          timer_en,
   output logic          busy,
   output logic          error,
   output logic [7:0]    word_cnt
);

   ld_state_e     state_q, state_d;
   logic [7:0]    n_q, n_d;
   logic [BW-1:0] hi_q, hi_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    wcnt_q, wcnt_d;
   logic [AW-1:0] ext_addr_q, ext_addr_d;
   logic [DW-1:0] ext_data_q, ext_data_d;

   logic receiving, accept, expire;

   assign receiving = (state_q == ST_HDR) || (state_q == ST_HI) || (state_q == ST_LO);
   assign accept    = receiving && rx_valid;

   // Held clear outside the receiving states, so it starts from zero on HDR entry.
   loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (accept || !receiving),
      .inc_i    (receiving && !accept),
      .expire_o (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         hi_q       <= '0;
         addr_q     <= '0;
         wcnt_q     <= '0;
         ext_addr_q <= '0;
         ext_data_q <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         hi_q       <= hi_d;
         addr_q     <= addr_d;
         wcnt_q     <= wcnt_d;
         ext_addr_q <= ext_addr_d;
         ext_data_q <= ext_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      hi_d       = hi_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      ext_addr_d = ext_addr_q;
      ext_data_d = ext_data_q;
      case (state_q)
         ST_IDLE, ST_HALT, ST_ERR: begin
            if (start) begin
               state_d = ST_HDR;
               wcnt_d  = '0;
            end
         end
         ST_HDR: begin
            if (accept) begin
               if (rx_data == '0) begin
                  state_d = ST_ERR;
               end else begin
                  n_d     = rx_data;
                  addr_d  = BASE_ADDR;
                  state_d = ST_HI;
               end
            end else if (expire) begin
               state_d = ST_ERR;
            end
         end
         ST_HI: begin
            if (accept) begin
               hi_d    = rx_data;
               state_d = ST_LO;
            end else if (expire) begin
               state_d = ST_ERR;
            end
         end
         ST_LO: begin
            // Write port registers load here so they are valid during WRITE
            // and hold afterwards.
            if (accept) begin
               ext_addr_d = addr_q;
               ext_data_d = {hi_q, rx_data};
               state_d    = ST_WRITE;
            end else if (expire) begin
               state_d = ST_ERR;
            end
         end
         ST_WRITE: begin
            wcnt_d  = wcnt_q + 8'd1;
            addr_d  = addr_q + 1'b1;
            state_d = (wcnt_q + 8'd1 == n_q) ? ST_RUN : ST_HI;
         end
         ST_RUN: begin
            if (cpu_done) state_d = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs decoded straight from the state register.
   assign rx_ready = receiving;
   assign ext_wen  = (state_q == ST_WRITE);
   assign ext_addr = ext_addr_q;
   assign ext_data = ext_data_q;
   assign timer_en = (state_q == ST_RUN);
   assign busy     = receiving || (state_q == ST_WRITE);
   assign error    = (state_q == ST_ERR);
   assign word_cnt = wcnt_q;

endmodule
